// File: rtl/fifo_stream_reader_if.sv
// Read-side bundle between the async FIFO read port, the drain engine and the downstream stream.
// master = drain engine (pops the FIFO, drives the stream); slave = FIFO plus stream consumer.
interface fifo_stream_reader_if #(
    parameter int data_width = 8
);
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [data_width-1:0] fifo_data;
    logic [data_width-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  m_ready,
        output fifo_rd_en,
        output m_data,
        output m_valid
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        output m_ready,
        input  fifo_rd_en,
        input  m_data,
        input  m_valid
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Async-FIFO read-side drain engine: pops words and re-presents them on a valid/ready stream via a 2-deep buffer.
// Optional accepted-word counter rd_count is built only when FIFO_RD_COUNT_EN is defined.
module fifo_stream_reader #(
    parameter int data_width = 8
`ifdef FIFO_RD_COUNT_EN
    ,
    parameter int count_width = 16
`endif
) (
    input  logic                   rd_clk,
    input  logic                   rst_n,
    input  logic                   enable,
    fifo_stream_reader_if.master   bus
`ifdef FIFO_RD_COUNT_EN
    ,
    output logic [count_width-1:0] rd_count
`endif
);

    logic [1:0]            cnt;
    logic                  inflight;
    logic [data_width-1:0] head_q;
    logic [data_width-1:0] tail_q;
    logic                  accept;
    logic [2:0]            occupancy;

    // Words already committed to the buffer once this edge settles; a pop is only
    // allowed if its word is guaranteed a free slot when it arrives next edge.
    assign accept         = bus.m_valid && bus.m_ready;
    assign occupancy      = {1'b0, cnt} + {2'b00, inflight} - {2'b00, accept};
    assign bus.fifo_rd_en = rst_n && enable && !bus.fifo_empty && (occupancy < 3'd2);
    assign bus.m_valid    = (cnt != 2'd0);
    assign bus.m_data     = head_q;

    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            cnt      <= 2'd0;
            inflight <= 1'b0;
            head_q   <= '0;
            tail_q   <= '0;
        end else begin
            inflight <= bus.fifo_rd_en;
            case ({inflight, accept})
                2'b11: begin
                    if (cnt == 2'd2) begin
                        head_q <= tail_q;
                        tail_q <= bus.fifo_data;
                    end else begin
                        head_q <= bus.fifo_data;
                    end
                end
                2'b10: begin
                    if (cnt == 2'd0) begin
                        head_q <= bus.fifo_data;
                    end else begin
                        tail_q <= bus.fifo_data;
                    end
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    cnt    <= cnt - 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FIFO_RD_COUNT_EN
    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            rd_count <= '0;
        end else if (accept) begin
            rd_count <= rd_count + 1'b1;
        end
    end
`endif

endmodule
